// File: rtl/tone_detector_iq.sv
// -----------------------------------------------------------------------------
// tone_detector_iq
//
// Quadrature tone detector. Each accepted sample is multiplied by the local
// cos/sin reference, and the two products are integrated over i_len samples.
// One I/Q/magnitude/overflow result is produced per run. Instantiate one
// detector per tone of interest.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   i_start    in   1      start a run (looked at only while idle)
//   i_len      in   CNT_W  samples per run, latched at start (0 = no run)
//   i_valid    in   1      i_sample / i_ref_cos / i_ref_sin valid this cycle
//   i_sample   in   IN_W   signed sample (1.3.14)
//   i_ref_cos  in   REF_W  signed cos reference (1.1.14)
//   i_ref_sin  in   REF_W  signed sin reference (1.1.14)
//   o_busy     out  1      run in progress
//   o_valid    out  1      one-cycle pulse when o_i/o_q/o_mag/o_ovf update
//   o_i        out  ACC_W  sum(sample*cos), signed, saturating
//   o_q        out  ACC_W  sum(sample*sin), signed, saturating
//   o_mag      out  ACC_W  max(|I|,|Q|) + min(|I|,|Q|)/2, unsigned
//   o_ovf      out  1      an accumulator saturated during the run
// -----------------------------------------------------------------------------
module tone_detector_iq #(
    parameter int IN_W  = 18,
    parameter int REF_W = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [CNT_W-1:0]        i_len,
    input  logic                    i_valid,
    input  logic signed [IN_W-1:0]  i_sample,
    input  logic signed [REF_W-1:0] i_ref_cos,
    input  logic signed [REF_W-1:0] i_ref_sin,
    output logic                    o_busy,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] o_i,
    output logic signed [ACC_W-1:0] o_q,
    output logic [ACC_W-1:0]        o_mag,
    output logic                    o_ovf
);

    localparam int PROD_W = IN_W + REF_W;
    // Adder wide enough for either operand plus a carry, so a narrow
    // accumulator (ACC_W < PROD_W) still sees the full product.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(ACC_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(ACC_MIN);
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DUMP  = 2'd3
    } state_t;

    // Saturating accumulate; sat reports that the result was clamped.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input  logic signed [ACC_W-1:0]  acc,
        input  logic signed [PROD_W-1:0] prod,
        output logic                     sat
    );
        logic signed [SUM_W-1:0] s;
        s       = SUM_W'(acc) + SUM_W'(prod);
        sat     = 1'b0;
        sat_add = s[ACC_W-1:0];
        if (s > SUM_MAX) begin
            sat     = 1'b1;
            sat_add = ACC_MAX;
        end else if (s < SUM_MIN) begin
            sat     = 1'b1;
            sat_add = ACC_MIN;
        end
    endfunction

    // |x| with the most-negative code folded onto the most-positive one.
    function automatic logic [ACC_W-1:0] abs_sat(input logic signed [ACC_W-1:0] x);
        if (x == ACC_MIN) begin
            abs_sat = $unsigned(ACC_MAX);
        end else if (x[ACC_W-1]) begin
            abs_sat = $unsigned(-x);
        end else begin
            abs_sat = $unsigned(x);
        end
    endfunction

    // Alpha-max-plus-beta-min magnitude (alpha = 1, beta = 1/2), clamped.
    function automatic logic [ACC_W-1:0] mag_approx(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic [ACC_W-1:0] aa;
        logic [ACC_W-1:0] bb;
        logic [ACC_W-1:0] hi;
        logic [ACC_W-1:0] lo;
        logic [ACC_W:0]   s;
        aa = abs_sat(a);
        bb = abs_sat(b);
        if (aa >= bb) begin
            hi = aa;
            lo = bb;
        end else begin
            hi = bb;
            lo = aa;
        end
        s = {1'b0, hi} + {2'b00, lo[ACC_W-1:1]};
        mag_approx = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    state_t                    state;
    logic [CNT_W-1:0]          len_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      ovf_q;

    logic                      accept_p0;
    logic signed [PROD_W-1:0]  samp_x_p0;
    logic signed [PROD_W-1:0]  cos_x_p0;
    logic signed [PROD_W-1:0]  sin_x_p0;

    logic                      vld_p1;
    logic signed [PROD_W-1:0]  prod_i_p1;
    logic signed [PROD_W-1:0]  prod_q_p1;

    logic signed [ACC_W-1:0]   acc_i_p2;
    logic signed [ACC_W-1:0]   acc_q_p2;
    logic signed [ACC_W-1:0]   acc_i_nxt;
    logic signed [ACC_W-1:0]   acc_q_nxt;
    logic                      sat_i;
    logic                      sat_q;

    // ---- stage 0: sample acceptance (only while running) ----
    assign accept_p0 = (state == RUN) && i_valid;
    assign samp_x_p0 = PROD_W'(i_sample);
    assign cos_x_p0  = PROD_W'(i_ref_cos);
    assign sin_x_p0  = PROD_W'(i_ref_sin);

    // ---- stage 1: full-precision mixer products ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            prod_i_p1 <= '0;
            prod_q_p1 <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                prod_i_p1 <= samp_x_p0 * cos_x_p0;
                prod_q_p1 <= samp_x_p0 * sin_x_p0;
            end
        end
    end

    // ---- stage 2: saturating integrate ----
    always_comb begin
        sat_i     = 1'b0;
        sat_q     = 1'b0;
        acc_i_nxt = sat_add(acc_i_p2, prod_i_p1, sat_i);
        acc_q_nxt = sat_add(acc_q_p2, prod_q_p1, sat_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            acc_i_p2 <= '0;
            acc_q_p2 <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_i      <= '0;
            o_q      <= '0;
            o_mag    <= '0;
            o_ovf    <= 1'b0;
        end else begin
            o_valid <= 1'b0;

            // vld_p1 is only ever set by RUN acceptances, so this fires in
            // RUN and in the single DRAIN cycle that follows the last sample.
            if (vld_p1) begin
                acc_i_p2 <= acc_i_nxt;
                acc_q_p2 <= acc_q_nxt;
                if (sat_i || sat_q) begin
                    ovf_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_start && (i_len != '0)) begin
                        len_q    <= i_len;
                        cnt_q    <= '0;
                        ovf_q    <= 1'b0;
                        acc_i_p2 <= '0;
                        acc_q_p2 <= '0;
                        o_busy   <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (i_valid) begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if ((cnt_q + CNT_ONE) == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    o_busy <= 1'b0;
                    state  <= DUMP;
                end
                DUMP: begin
                    o_i     <= acc_i_p2;
                    o_q     <= acc_q_p2;
                    o_mag   <= mag_approx(acc_i_p2, acc_q_p2);
                    o_ovf   <= ovf_q;
                    o_valid <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_detector_iq.sv
// -----------------------------------------------------------------------------
// tb_tone_detector_iq
//
// Drives two detectors from the same stimulus: the default 48-bit accumulator
// build and a 32-bit build that saturates readily. A reference model keeps
// the accepted samples of each run and recomputes I, Q, magnitude and the
// overflow flag with 64-bit integer arithmetic and stepwise clamping.
// -----------------------------------------------------------------------------
module tb_tone_detector_iq;

    localparam int CNT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    i_start;
    logic [CNT_W-1:0]        i_len;
    logic                    i_valid;
    logic signed [17:0]      i_sample;
    logic signed [15:0]      i_ref_cos;
    logic signed [15:0]      i_ref_sin;

    logic                    busy_a, vld_a, ovf_a;
    logic signed [47:0]      oi_a, oq_a;
    logic [47:0]             mag_a;
    logic                    busy_b, vld_b, ovf_b;
    logic signed [31:0]      oi_b, oq_b;
    logic [31:0]             mag_b;

    int n_vec = 0;
    int n_err = 0;

    int qs[$];
    int qc[$];
    int qn[$];

    always #5 clk = ~clk;

    tone_detector_iq dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
        .i_valid(i_valid), .i_sample(i_sample), .i_ref_cos(i_ref_cos),
        .i_ref_sin(i_ref_sin), .o_busy(busy_a), .o_valid(vld_a),
        .o_i(oi_a), .o_q(oq_a), .o_mag(mag_a), .o_ovf(ovf_a)
    );

    tone_detector_iq #(.ACC_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
        .i_valid(i_valid), .i_sample(i_sample), .i_ref_cos(i_ref_cos),
        .i_ref_sin(i_ref_sin), .o_busy(busy_b), .o_valid(vld_b),
        .o_i(oi_b), .o_q(oq_b), .o_mag(mag_b), .o_ovf(ovf_b)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clamp(input longint v, input int w);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic longint mag_ref(input longint i, input longint q, input int w);
        longint mx;
        longint ai;
        longint aq;
        longint hi;
        longint lo;
        longint m;
        longint lim;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        ai  = (i < -mx) ? mx : ((i < 0) ? -i : i);
        aq  = (q < -mx) ? mx : ((q < 0) ? -q : q);
        hi  = (ai > aq) ? ai : aq;
        lo  = (ai > aq) ? aq : ai;
        m   = hi + lo / 2;
        lim = (longint'(1) <<< w) - 1;
        return (m > lim) ? lim : m;
    endfunction

    task automatic model(input int w, output longint ei, output longint eq,
                         output longint em, output bit eo);
        longint raw;
        ei = 0;
        eq = 0;
        eo = 1'b0;
        foreach (qs[j]) begin
            raw = ei + longint'(qs[j]) * longint'(qc[j]);
            ei  = clamp(raw, w);
            if (ei != raw) eo = 1'b1;
            raw = eq + longint'(qs[j]) * longint'(qn[j]);
            eq  = clamp(raw, w);
            if (eq != raw) eo = 1'b1;
        end
        em = mag_ref(ei, eq, w);
    endtask

    task automatic drive_rand();
        i_sample  = 18'($urandom);
        i_ref_cos = 16'($urandom);
        i_ref_sin = 16'($urandom);
    endtask

    task automatic check_idle(input string nm);
        check_eq({nm, " busy"},    busy_a, 0);
        check_eq({nm, " valid"},   vld_a,  0);
        check_eq({nm, " i"},       oi_a,   0);
        check_eq({nm, " q"},       oq_a,   0);
        check_eq({nm, " mag"},     mag_a,  0);
        check_eq({nm, " ovf"},     ovf_a,  0);
        check_eq({nm, " busy32"},  busy_b, 0);
        check_eq({nm, " valid32"}, vld_b,  0);
        check_eq({nm, " i32"},     oi_b,   0);
        check_eq({nm, " q32"},     oq_b,   0);
        check_eq({nm, " mag32"},   mag_b,  0);
        check_eq({nm, " ovf32"},   ovf_b,  0);
    endtask

    // One complete run. rnd selects random sample/reference values, otherwise
    // s/c/sn are used for every sample. vmask gives the i_valid pattern for
    // the first vlen cycles (valid afterwards); vlen = 0 means random valids.
    task automatic do_run(input string nm, input int len, input bit rnd,
                          input int s, input int c, input int sn,
                          input logic [31:0] vmask, input int vlen,
                          input bit poke_start);
        longint ei48, eq48, em48, ei32, eq32, em32;
        bit     eo48, eo32;
        int     acc;
        int     k;
        int     cs, cc, cn;
        bit     v;
        qs.delete();
        qc.delete();
        qn.delete();

        // start cycle carries a valid sample that must not be integrated
        i_start = 1'b1;
        i_len   = CNT_W'(len);
        i_valid = 1'b1;
        drive_rand();
        step();
        i_start = 1'b0;
        check_eq({nm, " busy_start"}, busy_a, 1);

        acc = 0;
        k   = 0;
        while (acc < len && k < len * 8 + 64) begin
            if (vlen > 0) v = (k < vlen) ? vmask[k] : 1'b1;
            else          v = ($urandom_range(0, 9) < 7);
            if (rnd) begin
                cs = int'($urandom_range(0, 262143)) - 131072;
                cc = int'($urandom_range(0, 65535)) - 32768;
                cn = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                cs = s;
                cc = c;
                cn = sn;
            end
            i_sample  = 18'(cs);
            i_ref_cos = 16'(cc);
            i_ref_sin = 16'(cn);
            i_valid   = v;
            i_start   = poke_start && ($urandom_range(0, 3) == 0);
            i_len     = CNT_W'($urandom_range(1, 9));
            step();
            if (v) begin
                qs.push_back(cs);
                qc.push_back(cc);
                qn.push_back(cn);
                acc++;
            end
            k++;
        end
        i_start = 1'b0;

        // last sample accepted; still busy while the final product drains
        check_eq({nm, " busy_drain"}, busy_a, 1);
        i_valid = 1'b1;
        drive_rand();
        step();
        check_eq({nm, " valid_early"}, vld_a, 0);
        check_eq({nm, " busy_dump"},   busy_a, 0);
        i_valid = 1'b0;
        step();

        model(48, ei48, eq48, em48, eo48);
        model(32, ei32, eq32, em32, eo32);
        check_eq({nm, " valid"},   vld_a, 1);
        check_eq({nm, " valid32"}, vld_b, 1);
        check_eq({nm, " i"},       oi_a,  ei48);
        check_eq({nm, " q"},       oq_a,  eq48);
        check_eq({nm, " mag"},     mag_a, em48);
        check_eq({nm, " ovf"},     ovf_a, longint'(eo48));
        check_eq({nm, " i32"},     oi_b,  ei32);
        check_eq({nm, " q32"},     oq_b,  eq32);
        check_eq({nm, " mag32"},   mag_b, em32);
        check_eq({nm, " ovf32"},   ovf_b, longint'(eo32));
        step();
        check_eq({nm, " valid_pulse"}, vld_a, 0);
        check_eq({nm, " i_hold"},      oi_a,  ei48);
    endtask

    initial begin
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_len     = '0;
        i_valid   = 1'b0;
        i_sample  = '0;
        i_ref_cos = '0;
        i_ref_sin = '0;
        repeat (3) step();
        check_idle("reset");
        rst_n = 1'b1;
        step();

        do_run("cos4",    4, 1'b0,  16384, 16384,     0, 32'd0,   0, 1'b0);
        do_run("cos4gap", 4, 1'b0,  16384, 16384,     0, 32'd105, 7, 1'b0);
        do_run("sin3",    3, 1'b0, -16384,     0, 16384, 32'd0,   0, 1'b0);
        do_run("both2",   2, 1'b0,  16384, 16384, 16384, 32'd0,   0, 1'b0);
        do_run("sat1",    1, 1'b0, 131071, 32767,     0, 32'd0,   0, 1'b0);
        do_run("postsat", 2, 1'b0,    100,   200,  -300, 32'd0,   0, 1'b0);

        // reset in the middle of a len=5 run, after two samples
        i_start = 1'b1;
        i_len   = CNT_W'(5);
        i_valid = 1'b0;
        step();
        i_start = 1'b0;
        repeat (2) begin
            i_valid = 1'b1;
            drive_rand();
            step();
        end
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_idle("midrst");
        step();
        rst_n = 1'b1;
        step();

        do_run("fresh", 2, 1'b1, 0, 0, 0, 32'd0, 0, 1'b1);

        // zero length start is ignored
        i_start = 1'b1;
        i_len   = '0;
        i_valid = 1'b1;
        drive_rand();
        step();
        i_start = 1'b0;
        i_valid = 1'b0;
        check_eq("len0 busy", busy_a, 0);
        step();
        step();
        check_eq("len0 valid", vld_a, 0);

        for (int r = 0; r < 12; r++) begin
            do_run("rnd", int'($urandom_range(1, 12)), 1'b1, 0, 0, 0, 32'd0, 0, r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
